// File: rtl/llki_mock_tss_key_sink.sv
// Mock TSS key sink: accepts two masked 64-bit key words with artificial
// wait states, exposes the unmasked key only when complete, supports clear.
module llki_mock_tss_key_sink #(
  parameter logic [7:0]  WAIT_CYCLES = 8'h0A,
  parameter logic [63:0] KEY_MASK_0  = 64'h0123456789ABCDEF,
  parameter logic [63:0] KEY_MASK_1  = 64'hFEDCBA9876543210
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [63:0]  llkid_key_data,
  input  logic         llkid_key_valid,
  output logic         llkid_key_ready,
  output logic         llkid_key_complete,
  input  logic         llkid_clear_key,
  output logic         llkid_clear_key_ack,
  output logic [127:0] key_out
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_STATE0,
    KEY0_LOADED,
    WAIT_STATE1,
    KEY1_LOADED,
    CLEAR_KEY,
    WAIT_STATE2
  } state_e;

  state_e         state_q, state_d;
  logic [127:0]   key_reg_q, key_reg_d;
  logic [7:0]     cnt_q, cnt_d;
  logic           ack_q, ack_d;
  logic           xfer;

  assign llkid_key_ready = ((state_q == IDLE) || (state_q == KEY0_LOADED))
                           && !llkid_clear_key;
  assign llkid_key_complete  = (state_q == KEY1_LOADED);
  assign llkid_clear_key_ack = ack_q;
  assign key_out = llkid_key_complete ? key_reg_q : 128'h0;
  assign xfer = llkid_key_valid && llkid_key_ready;

  always_comb begin
    state_d   = state_q;
    key_reg_d = key_reg_q;
    cnt_d     = cnt_q;
    ack_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (llkid_clear_key) begin
          state_d = CLEAR_KEY;
        end else if (xfer) begin
          key_reg_d[63:0] = llkid_key_data ^ KEY_MASK_0;
          cnt_d           = WAIT_CYCLES;
          state_d         = WAIT_STATE0;
        end
      end
      WAIT_STATE0: begin
        if (llkid_clear_key) begin
          state_d = CLEAR_KEY;
        end else if (cnt_q == 8'd1) begin
          state_d = KEY0_LOADED;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      KEY0_LOADED: begin
        if (llkid_clear_key) begin
          state_d = CLEAR_KEY;
        end else if (xfer) begin
          key_reg_d[127:64] = llkid_key_data ^ KEY_MASK_1;
          cnt_d             = WAIT_CYCLES;
          state_d           = WAIT_STATE1;
        end
      end
      WAIT_STATE1: begin
        if (llkid_clear_key) begin
          state_d = CLEAR_KEY;
        end else if (cnt_q == 8'd1) begin
          state_d = KEY1_LOADED;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      KEY1_LOADED: begin
        if (llkid_clear_key) begin
          state_d = CLEAR_KEY;
        end
      end
      CLEAR_KEY: begin
        key_reg_d = 128'h0;
        cnt_d     = WAIT_CYCLES;
        state_d   = WAIT_STATE2;
      end
      WAIT_STATE2: begin
        // clear input is deliberately ignored until back in IDLE
        if (cnt_q == 8'd1) begin
          state_d = IDLE;
          ack_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      key_reg_q <= 128'h0;
      cnt_q     <= 8'h0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      key_reg_q <= key_reg_d;
      cnt_q     <= cnt_d;
      ack_q     <= ack_d;
    end
  end

endmodule

// File: doc/llki_mock_tss_key_sink.md
LLKI_MOCK_TSS_KEY_SINK -- requirements
Module: llki_mock_tss_key_sink

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 8'h0A, giving the number of artificial wait-state cycles per key word and per clear (legal range 1..255).
REQ-002 SHALL have parameter KEY_MASK_0, default 64'h0123456789ABCDEF, which is XORed with key word #1.
REQ-003 SHALL have parameter KEY_MASK_1, default 64'hFEDCBA9876543210, which is XORed with key word #2.
REQ-004 clk  input  1  sole clock; all state changes on the rising edge.
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 llkid_key_data  input  64  key word from the upstream LLKI-PP.
REQ-007 llkid_key_valid  input  1  llkid_key_data is valid this cycle.
REQ-008 llkid_key_ready  output  1  the block can accept a key word this cycle.
REQ-009 llkid_key_complete  output  1  both key words are loaded.
REQ-010 llkid_clear_key  input  1  request to clear the internal key (locks the core).
REQ-011 llkid_clear_key_ack  output  1  single-cycle pulse signalling that the clear has finished.
REQ-012 key_out  output  128  unmasked key to the protected core; {word2^KEY_MASK_1, word1^KEY_MASK_0}.

Function
REQ-013 SHALL implement these states: IDLE, WAIT_STATE0, KEY0_LOADED, WAIT_STATE1, KEY1_LOADED, CLEAR_KEY, WAIT_STATE2.
REQ-014 A word transfer SHALL occur only on a cycle where llkid_key_valid=1 and llkid_key_ready=1.
REQ-015 llkid_key_ready SHALL be 1 only in IDLE and KEY0_LOADED, and only while llkid_clear_key=0; it is 0 in all other states.
REQ-016 In IDLE, a transfer SHALL:
- latch llkid_key_data^KEY_MASK_0 into key_reg[63:0];
- load the wait counter with WAIT_CYCLES;
- move to WAIT_STATE0 on the next edge.
REQ-017 WAIT_STATE0 and WAIT_STATE1 SHALL each last exactly WAIT_CYCLES cycles (counter decrements each cycle; exit when it reaches 1). WAIT_STATE0 then goes to KEY0_LOADED and WAIT_STATE1 to KEY1_LOADED.
REQ-018 In KEY0_LOADED, a transfer SHALL:
- latch llkid_key_data^KEY_MASK_1 into key_reg[127:64];
- reload the counter with WAIT_CYCLES;
- move to WAIT_STATE1.
REQ-019 llkid_key_complete SHALL be 1 only in KEY1_LOADED.
REQ-020 key_out SHALL equal key_reg while llkid_key_complete=1 and SHALL be 128'h0 otherwise, so no partial key reaches the core.
REQ-021 In KEY1_LOADED, llkid_key_valid SHALL be ignored: no state change and no change to key_reg.
REQ-022 llkid_clear_key=1 in IDLE, WAIT_STATE0, KEY0_LOADED, WAIT_STATE1 or KEY1_LOADED SHALL move to CLEAR_KEY on the next edge. It takes priority over a simultaneous llkid_key_valid, and that word is not captured.
REQ-023 CLEAR_KEY SHALL last one cycle: zero key_reg, load the counter with WAIT_CYCLES, then go to WAIT_STATE2.
REQ-024 WAIT_STATE2 SHALL last WAIT_CYCLES cycles. It then goes to IDLE with llkid_clear_key_ack=1 for exactly the first IDLE cycle.
REQ-025 llkid_clear_key SHALL be ignored in CLEAR_KEY and WAIT_STATE2; a level held through those states does not start a second clear.
REQ-026 A clear issued in IDLE with key_reg already zero SHALL still perform the full CLEAR_KEY/WAIT_STATE2 sequence and produce the ack.
REQ-027 The wait counter SHALL be 8 bits and SHALL never underflow, because every wait state exits at count 1.

Reset
REQ-028 While rst=1 on a clock edge, the block SHALL enter IDLE, zero key_reg and zero the counter.
REQ-029 Reset values of the outputs SHALL be: llkid_key_ready=1 (IDLE), llkid_key_complete=0, llkid_clear_key_ack=0, key_out=128'h0.
REQ-030 Reset asserted mid-load or mid-clear SHALL abort the operation with no ack and no partial key retained.

Verification
REQ-031 Normal load: send word1=64'h0 in IDLE, then word2=64'h0 when ready returns. Required: ready low for exactly 10 cycles after each transfer; llkid_key_complete=1 after the second wait; key_out=128'hFEDCBA9876543210_0123456789ABCDEF.
REQ-032 Masking: send word1=64'hFFFFFFFFFFFFFFFF and word2=64'h0123456789ABCDEF. Required: key_out=128'hFFFFFFFFFFFFFFFF_FEDCBA9876543210.
REQ-033 Clear after load: complete key, then pulse clear for 1 cycle. Required: complete drops on the next edge; key_out=0; ack pulses once, 1+10 cycles after CLEAR_KEY is entered; ready=1 in that same cycle.
REQ-034 Simultaneous valid and clear in KEY0_LOADED. Required: word not captured; clear sequence runs; after the ack, a fresh two-word load yields the correct key.
REQ-035 Hold valid=1 continuously through KEY1_LOADED for 20 cycles with changing data. Required: key_out unchanged, ready=0 throughout.
REQ-036 Assert rst during WAIT_STATE1. Required: next cycle ready=1, complete=0, key_out=0, no ack pulse.
